booth_mult_host: RTL and testbench
==================================

Name: booth_mult_host

Overview:
- Initiator/driver for the serial 4-bit Booth multiplier; the multiplier is the responder.
- Accepts a full-width operand pair from a user-side ready/valid port and runs the multiplier's nibble-serial protocol: start pulse, multiplicand, multiplier.
- Waits for done, reassembles the 2*WIDTH-bit product from two result beats, and returns it on a user-side valid/ready port.
- Includes a watchdog that aborts a hung transaction.

Parameters:
- WIDTH, 4, operand width; also the width of the serial data bus to and from the multiplier.
- TIMEOUT, 32, max cycles spent in WAIT for done before aborting (must be ≥ 2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- op_valid  input  1  user operand pair valid.
- op_ready  output  1  host can accept an operand pair.
- op_a  input  WIDTH  multiplicand (two's complement).
- op_b  input  WIDTH  multiplier (two's complement).
- res_valid  output  1  product or error available.
- res_ready  input  1  user accepts the result.
- res_product  output  2*WIDTH  signed product; 0 when res_error=1.
- res_error  output  1  timeout abort flag, qualified by res_valid.
- m_start  output  1  start pulse to the multiplier.
- m_data  output  WIDTH  serial operand bus to the multiplier's data_in.
- m_result  input  WIDTH  serial result bus from the multiplier's data_out.
- m_done  input  1  multiplier done strobe.

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - op_ready=1, res_valid=0, res_error=0, res_product=0, m_start=0, m_data=0.
  - Watchdog=0, operand registers=0.
  - Reset asserted mid-transaction aborts it immediately. No partial result is ever presented.
- All outputs are registered. m_data is 0 in every state except SEND_A and SEND_B.
- IDLE: op_ready=1. On op_valid&op_ready, latch op_a/op_b, drop op_ready, go to START.
- START: one cycle with m_start=1, then go to SEND_A.
- SEND_A: m_data=latched op_a for exactly one cycle, then go to SEND_B.
- SEND_B: m_data=latched op_b for exactly one cycle, then go to WAIT and clear the watchdog.
- WAIT: watchdog increments each cycle.
  - m_done=1: capture m_result as the product low half (bits WIDTH-1:0), go to CAP_HI.
  - Watchdog reaches TIMEOUT-1 without m_done: set res_error=1, res_product=0, go to RESP.
  - m_done and timeout in the same cycle: m_done wins.
- CAP_HI: capture m_result (cycle after done) as the high half (bits 2W-1:W), go to RESP. m_done is ignored here.
- RESP: res_valid=1; res_product and res_error are held stable until res_ready=1.
  - On res_valid&res_ready: clear res_valid and res_error, go to IDLE.
  - op_ready is asserted again on the following cycle, so there is no back-to-back accept in the handshake cycle.
- m_done outside WAIT is ignored.
- op_valid while op_ready=0 is ignored; the user must hold it.
- Latency (no backpressure, done after D WAIT cycles): accept → m_start 1 cycle; start→SEND_A→SEND_B→WAIT = 3 cycles; then D + 2 cycles to res_valid.
- No arithmetic is performed in the host; the product is the concatenation {high beat, low beat}.

Test Plan:
1. Basic: op_a=4'b1101 (-3), op_b=4'b1010 (-6); multiplier model returns low=4'h2 then high=4'h1 after 8 WAIT cycles.
   -> m_start high 1 cycle; m_data=D then A on consecutive cycles; res_product=8'h12 (+18), res_error=0.
2. Backpressure: same as 1 with res_ready held low 5 cycles after res_valid.
   -> res_product/res_valid stable, op_ready=0 throughout; released one cycle after handshake.
3. Timeout: model never asserts m_done, TIMEOUT=32.
   -> res_valid with res_error=1, res_product=0 exactly 32 WAIT cycles after SEND_B; next op accepted normally.
4. Done/timeout collision: m_done asserted in the last watchdog cycle.
   -> normal product, res_error=0.
5. Async reset in WAIT: drop rst between clock edges.
   -> all outputs reach reset values immediately; after release, op_ready=1; stray m_done/m_result ignored, no res_valid.
6. Spurious m_done in IDLE/SEND_A, and op_valid held during busy.
   -> no state change from the done; exactly one transaction per accepted handshake.

Source files
------------

// File: rtl/booth_mult_host_if.sv
// Bundles the user operand/result handshake and the serial multiplier bus.
// master is the host's view; slave is the view of whatever sits around it.
interface booth_mult_host_if #(
  parameter int WIDTH = 4
);
  logic                 op_valid;
  logic                 op_ready;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*WIDTH-1:0]   res_product;
  logic                 res_error;
  logic                 m_start;
  logic [WIDTH-1:0]     m_data;
  logic [WIDTH-1:0]     m_result;
  logic                 m_done;

  modport master (
    input  op_valid, op_a, op_b, res_ready, m_result, m_done,
    output op_ready, res_valid, res_product, res_error, m_start, m_data
  );

  modport slave (
    output op_valid, op_a, op_b, res_ready, m_result, m_done,
    input  op_ready, res_valid, res_product, res_error, m_start, m_data
  );
endinterface

// File: rtl/booth_mult_host.sv
// Host for the nibble-serial Booth multiplier: sends start/A/B, waits for done,
// reassembles the two result beats and returns the product, with a watchdog.
module booth_mult_host #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  booth_mult_host_if.master bus
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_A,
    S_SEND_B,
    S_WAIT,
    S_CAP_HI,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 err_q, err_d;
  logic                 op_ready_q, op_ready_d;
  logic                 res_valid_q, res_valid_d;
  logic                 m_start_q, m_start_d;
  logic [WIDTH-1:0]     m_data_q, m_data_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      wdog_q      <= '0;
      prod_q      <= '0;
      err_q       <= 1'b0;
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      m_start_q   <= 1'b0;
      m_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      wdog_q      <= wdog_d;
      prod_q      <= prod_d;
      err_q       <= err_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      m_start_q   <= m_start_d;
      m_data_q    <= m_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    wdog_d  = wdog_q;
    prod_d  = prod_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.op_valid && op_ready_q) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          state_d = S_START;
        end
      end
      S_START:  state_d = S_SEND_A;
      S_SEND_A: state_d = S_SEND_B;
      S_SEND_B: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a watchdog expiring in the same cycle
        if (bus.m_done) begin
          prod_d[WIDTH-1:0] = bus.m_result;
          state_d           = S_CAP_HI;
        end else if (wdog_q == WD_LAST) begin
          err_d   = 1'b1;
          prod_d  = '0;
          state_d = S_RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_CAP_HI: begin
        prod_d[2*WIDTH-1:WIDTH] = bus.m_result;
        state_d                 = S_RESP;
      end
      S_RESP: begin
        if (bus.res_ready) begin
          err_d   = 1'b0;
          prod_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    op_ready_d  = (state_d == S_IDLE);
    res_valid_d = (state_d == S_RESP);
    m_start_d   = (state_d == S_START);
    m_data_d    = '0;
    if (state_d == S_SEND_A) begin
      m_data_d = a_d;
    end else if (state_d == S_SEND_B) begin
      m_data_d = b_d;
    end
  end

  assign bus.op_ready    = op_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_product = prod_q;
  assign bus.res_error   = err_q;
  assign bus.m_start     = m_start_q;
  assign bus.m_data      = m_data_q;

endmodule

// File: tb/tb_booth_mult_host.sv
// Bench for booth_mult_host: table vectors, randomized transactions against an
// arithmetic multiplier model, plus async-reset and stray-done sequences.
module tb_booth_mult_host;

  localparam int W       = 4;
  localparam int TIMEOUT = 32;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  booth_mult_host_if #(.WIDTH(W)) bus ();

  booth_mult_host #(.WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         dly;
    int         bp;
    bit         stray;
    bit         hold;
    logic [7:0] exp_p;
    bit         exp_e;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signed product of two 4-bit two's-complement operands, as an 8-bit value.
  function automatic logic [7:0] model_product(input logic [3:0] a, input logic [3:0] b);
    int sa;
    int sb;
    int p;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    p  = sa * sb;
    return p[7:0];
  endfunction

  task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input int dly,
                         input int bp, input bit stray, input bit hold,
                         input logic [7:0] exp_p, input bit exp_e, input int id);
    int         n;
    int         resp_k;
    int         exp_k;
    logic [7:0] beats;
    logic [7:0] held_p;
    bit         held_e;
    beats  = model_product(a, b);
    exp_k  = (dly > TIMEOUT) ? TIMEOUT + 1 : dly + 2;
    n = 0;
    while (!bus.op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("op_ready_idle", bus.op_ready, 1);
    if (stray) begin
      bus.m_done   = 1'b1;
      bus.m_result = 4'($urandom);
    end
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    @(negedge clk);
    if (hold) begin
      bus.op_a = 4'($urandom);
      bus.op_b = 4'($urandom);
    end else begin
      bus.op_valid = 1'b0;
    end
    check("start_pulse", bus.m_start, 1);
    check("busy_op_ready", bus.op_ready, 0);
    check("start_m_data", bus.m_data, 0);
    @(negedge clk);
    check("send_a_start", bus.m_start, 0);
    check("send_a_data", bus.m_data, a);
    @(negedge clk);
    check("send_b_data", bus.m_data, b);
    bus.m_done = 1'b0;
    resp_k = -1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        resp_k = k;
        break;
      end
      check("wait_m_data", bus.m_data, 0);
      check("wait_m_start", bus.m_start, 0);
      if (k == dly) begin
        bus.m_done   = 1'b1;
        bus.m_result = beats[3:0];
      end else if (k == dly + 1) begin
        bus.m_done   = stray;
        bus.m_result = beats[7:4];
      end else begin
        bus.m_done   = 1'b0;
        bus.m_result = 4'($urandom);
      end
    end
    bus.m_done   = 1'b0;
    bus.op_valid = 1'b0;
    check("resp_latency", resp_k, exp_k);
    check("res_product", bus.res_product, exp_p);
    check("res_error", bus.res_error, exp_e);
    check("resp_op_ready", bus.op_ready, 0);
    held_p = bus.res_product;
    held_e = bus.res_error;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_product", bus.res_product, held_p);
      check("bp_error", bus.res_error, held_e);
      check("bp_op_ready", bus.op_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("post_res_valid", bus.res_valid, 0);
    check("post_op_ready", bus.op_ready, 1);
    check("post_res_error", bus.res_error, 0);
    check("post_m_start", bus.m_start, 0);
    $display("txn %0d a=%h b=%h dly=%0d bp=%0d product=%h error=%0d expected=%h/%0d",
             id, a, b, dly, bp, held_p, held_e, exp_p, exp_e);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    bus.m_done    = 1'b0;
    bus.m_result  = '0;

    tbl[0] = '{4'hD, 4'hA,  8, 0, 1'b0, 1'b0, 8'h12, 1'b0};
    tbl[1] = '{4'hD, 4'hA,  8, 5, 1'b0, 1'b0, 8'h12, 1'b0};
    tbl[2] = '{4'h3, 4'h5, 40, 0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{4'h7, 4'h7,  1, 0, 1'b0, 1'b0, 8'h31, 1'b0};
    tbl[4] = '{4'h8, 4'h8, 32, 0, 1'b0, 1'b0, 8'h40, 1'b0};
    tbl[5] = '{4'h8, 4'h7, 31, 2, 1'b1, 1'b0, 8'hC8, 1'b0};
    tbl[6] = '{4'h5, 4'hF,  2, 1, 1'b1, 1'b1, 8'hFB, 1'b0};
    tbl[7] = '{4'h0, 4'h9,  3, 0, 1'b0, 1'b0, 8'h00, 1'b0};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_op_ready", bus.op_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_error", bus.res_error, 0);
    check("rst_res_product", bus.res_product, 0);
    check("rst_m_start", bus.m_start, 0);
    check("rst_m_data", bus.m_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].a, tbl[i].b, tbl[i].dly, tbl[i].bp, tbl[i].stray, tbl[i].hold,
              tbl[i].exp_p, tbl[i].exp_e, i);
    end

    for (int i = 0; i < 20; i++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      int         rd;
      ra = 4'($urandom);
      rb = 4'($urandom);
      rd = $urandom_range(1, 36);
      run_txn(ra, rb, rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              (rd > TIMEOUT) ? 8'h00 : model_product(ra, rb), rd > TIMEOUT, 100 + i);
    end

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_a     = 4'h3;
    bus.op_b     = 4'h3;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    bus.m_done   = 1'b1;
    bus.m_result = 4'hF;
    #1;
    check("arst_op_ready", bus.op_ready, 1);
    check("arst_res_valid", bus.res_valid, 0);
    check("arst_res_error", bus.res_error, 0);
    check("arst_res_product", bus.res_product, 0);
    check("arst_m_start", bus.m_start, 0);
    check("arst_m_data", bus.m_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_res_valid", bus.res_valid, 0);
      check("post_rst_op_ready", bus.op_ready, 1);
      check("post_rst_m_start", bus.m_start, 0);
    end
    bus.m_done = 1'b0;
    $display("txn reset_in_wait op_ready=%0d res_valid=%0d", bus.op_ready, bus.res_valid);

    run_txn(4'hD, 4'hA, 5, 0, 1'b1, 1'b0, 8'h12, 1'b0, 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
